// File: rtl/sr_latch_bank_pkg.sv
// sr_latch_bank_pkg: conflict-policy enum and shared helpers for the
// sr_latch_bank set/reset storage bank.
package sr_latch_bank_pkg;

  typedef enum logic [1:0] {
    MODE_RESET_DOM = 2'd0,
    MODE_SET_DOM   = 2'd1,
    MODE_HOLD      = 2'd2,
    MODE_TOGGLE    = 2'd3
  } mode_e;

  // Width of the glitch-filter counter; a one-cycle filter still needs one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

  // Next latch state from the filtered set/reset pair. both_prev is the
  // previous-cycle coincidence, so TOGGLE flips only on the rising edge of s&r.
  function automatic logic latch_next(
    input mode_e mode,
    input logic  sf,
    input logic  rf,
    input logic  both_prev,
    input logic  q
  );
    logic nq;
    nq = q;
    unique case ({sf, rf})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        unique case (mode)
          MODE_RESET_DOM: nq = 1'b0;
          MODE_SET_DOM:   nq = 1'b1;
          MODE_HOLD:      nq = q;
          MODE_TOGGLE:    nq = both_prev ? q : ~q;
          default:        nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_latch_chan.sv
// sr_latch_chan: one channel -- input synchronisers, optional glitch filter
// (compiled in by SR_LATCH_BANK_FILTER_EN), conflict-resolving latch, sticky flags.
module sr_latch_chan
  import sr_latch_bank_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  ena,
  input  logic  s,
  input  logic  r,
  input  mode_e mode,
  input  logic  clr_evt,
  output logic  q,
  output logic  evt,
  output logic  both_err
);

  // Index 0 carries set, index 1 carries reset through sync and filter.
  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync;
  logic [1:0]                  sync_out;
  logic [1:0]                  filt;

  assign raw = {r, s};

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every flop samples pre-edge values and the shift chain cannot collapse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_out[i] = sync[i][SYNC_STAGES-1];
    end
  end

`ifdef SR_LATCH_BANK_FILTER_EN
  localparam int CNT_W = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] cnt [2];

  // The filtered value moves only after FILTER_CYCLES consecutive enabled
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else if (ena) begin
      for (int i = 0; i < 2; i++) begin
        if (sync_out[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= sync_out[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign filt = sync_out;
`endif

  logic sf;
  logic rf;
  logic both;
  logic both_prev;
  logic q_next;
  logic q_change;

  assign sf   = filt[0];
  assign rf   = filt[1];
  assign both = sf & rf;

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next   = q;
    q_change = 1'b0;
    if (ena) begin
      q_next   = latch_next(mode, sf, rf, both_prev, q);
      q_change = (q_next != q);
    end
  end

  // Flags set on the same edge as the event; a set beats a coincident clear,
  // and clear still works while the bank is frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= 1'b0;
      both_prev <= 1'b0;
      evt       <= 1'b0;
      both_err  <= 1'b0;
    end else begin
      if (ena) begin
        q         <= q_next;
        both_prev <= both;
      end
      if (q_change) begin
        evt <= 1'b1;
      end else if (clr_evt) begin
        evt <= 1'b0;
      end
      if (ena && both) begin
        both_err <= 1'b1;
      end else if (clr_evt) begin
        both_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: CHANNELS independent clocked set/reset bits with shared
// conflict policy; the glitch filter is compiled in by SR_LATCH_BANK_FILTER_EN.
module sr_latch_bank
  import sr_latch_bank_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic [1:0]          mode,
  input  logic                clr_evt,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] qb,
  output logic [CHANNELS-1:0] evt,
  output logic [CHANNELS-1:0] both_err
);

  mode_e mode_sel;

  // Every 2-bit encoding is a legal policy, so the cast is lossless.
  assign mode_sel = mode_e'(mode);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sr_latch_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .s        (s[i]),
      .r        (r[i]),
      .mode     (mode_sel),
      .clr_evt  (clr_evt),
      .q        (q[i]),
      .evt      (evt[i]),
      .both_err (both_err[i])
    );
  end

  assign qb = ~q;

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Multi-channel, clocked successor to the single analog set/reset latch cell. It provides CHANNELS independent set/reset storage bits, each with its own input synchroniser and optional glitch filter. Behaviour when set and reset are both active is selectable at runtime. Sticky change and conflict flags let firmware or a scan chain poll the bank. It sits between the dedicated input pins and the output pins of the tile and replaces the hand-drawn latch wherever deterministic, clocked behaviour is required.

## Interface
- CHANNELS, 4, number of independent latch channels (1..8)
- SYNC_STAGES, 2, synchroniser flops per input (>=2)
- FILTER_CYCLES, 4, consecutive stable cycles required before a filtered input changes (>=1; used only with the filter compiled in)
- clk  input  1  single clock for all state
- rst_n  input  1  reset, synchronous and active-low
- ena  input  1  1 = update latch state and flags; 0 = hold q, filter state and flags
- s  input  CHANNELS  asynchronous set request per channel, active-high
- r  input  CHANNELS  asynchronous reset request per channel, active-high
- mode  input  2  conflict policy for s&r: 0 RESET_DOM, 1 SET_DOM, 2 HOLD, 3 TOGGLE
- clr_evt  input  1  one-cycle pulse that clears evt and both_err
- q  output  CHANNELS  latch state
- qb  output  CHANNELS  always ~q
- evt  output  CHANNELS  sticky: channel q changed since last clear
- both_err  output  CHANNELS  sticky: filtered s and r seen high together

## Operation
- Per-channel pipeline: synchroniser, then filter, then latch update.
- Synchronisers run every cycle, regardless of ena.
- Filter (per input): register f and counter cnt.
  - If sync_out == f: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: f <= sync_out and cnt <= 0.
  - Else: cnt <= cnt+1.
  - A pulse shorter than FILTER_CYCLES cycles at sync_out is discarded.
- Latch update, when ena=1, on the filtered pair (sf, rf):
  - sf=1, rf=0: q <= 1.
  - sf=0, rf=1: q <= 0.
  - sf=0, rf=0: q holds.
  - sf=1, rf=1: RESET_DOM sets q <= 0; SET_DOM sets q <= 1; HOLD keeps q; TOGGLE sets q <= ~q once, only on the cycle both first becomes true.
- A registered both_prev bit per channel detects the TOGGLE edge. both_prev updates only when ena=1.
- A mode change takes effect on the next clock edge. Changing mode while s&r are held never produces a TOGGLE unless a new both-edge occurs.
- evt[i] <= 1 on any cycle where q[i] changes. both_err[i] <= 1 on any cycle where sf&rf is true.
- clr_evt clears evt and both_err. When a set condition and clr_evt occur on the same cycle, set wins.
- ena=0 freezes q, f, cnt, both_prev, evt and both_err. clr_evt still works while ena=0.

## Timing
- Reset (rst_n low at an edge): q=0, qb=all ones, evt=0, both_err=0. All synchroniser flops, f, cnt and both_prev are 0.
- Reset mid-operation discards partial filter counts and in-flight synchroniser data. Outputs take their reset values after that edge.
- Latency with the filter compiled in: input stable before edge k makes q change after edge k+SYNC_STAGES+FILTER_CYCLES. With the defaults this is 7 edges including edge k.
- Latency without the filter: q changes after edge k+SYNC_STAGES, i.e. 3 edges with defaults.
- evt and both_err are asserted on the same edge as the corresponding q change or conflict.
- qb is combinational from q, with no extra latency.

## Configuration
- SR_LATCH_BANK_FILTER_EN defined: filter present as described. FILTER_CYCLES is honoured and cnt is max($clog2(FILTER_CYCLES),1) bits.
- SR_LATCH_BANK_FILTER_EN undefined: f = sync_out directly, no counters are instantiated, and FILTER_CYCLES is ignored.

## Structure
- Package sr_latch_bank_pkg holds the mode enum and the MODE_RESET_DOM/SET_DOM/HOLD/TOGGLE constants.
- Sub-module sr_latch_chan implements one channel: synchronisers, filter, latch, both_prev and flags. The top generates CHANNELS instances and shares mode, ena and clr_evt across them.

## Test plan
- Reset with s=r=0: q=0, qb=4'hF, flags 0. Then s[0] high for 10 cycles: q[0]=1 exactly 7 edges after the first sampling edge, and evt[0]=1.
- Filter: s[1] pulse of 3 cycles leaves q[1]=0 with evt clear. A pulse of 4 cycles sets q[1]=1. Without the macro, a 1-cycle pulse sets q[1].
- Conflict policy: s[2]=r[2]=1 held, with results checked for each mode:
  - mode 0: q[2]=0.
  - mode 1: q[2]=1.
  - mode 2: q[2] holds its prior value.
  - mode 3: q[2] toggles exactly once while held, then toggles again after release and re-assert.
  - both_err[2]=1 in every case.
- Flags: clr_evt coincident with a q change keeps evt=1. clr_evt alone clears evt and both_err to 0.
- ena=0 while s[3] changes: q[3] is frozen. After ena=1, q[3] updates after 1 edge if the filtered value has already settled.
- rst_n low for 1 cycle while a filter count is mid-way: all outputs return to reset values, and the partial count does not complete afterwards.
